i2c_bus_conditioner: RTL and testbench
======================================

// Module: i2c_bus_conditioner
// PURPOSE
//  Pad-side stage between i2c_master_wb's I2C pins and the open-drain SCL/SDA pads.
//  Synchronises and glitch-filters the pad inputs, then feeds them to the master's i2c_scl_i/i2c_sda_i.
//  Detects START/STOP, tracks bus busy, flags SCL held low, and runs a 9-clock bus-recovery sequence.
// PARAMETERS
//  FILTER_CYCLES    4     consecutive mismatching samples before filtered level flips; 0 = bypass
//  BUS_FREE_CYCLES  256   SCL=SDA=1 this long clears bus_busy without a STOP; 0 = disabled
//  STUCK_CYCLES     65535 SCL low this long asserts scl_stuck; 0 = disabled
//  RECOVER_HALF     250   recovery SCL half-period in clk cycles (>=1)
// PORTS
//  clk            in  1  clock
//  rst            in  1  asynchronous, active-low reset
//  scl_pad_i      in  1  raw SCL pad level
//  sda_pad_i      in  1  raw SDA pad level
//  scl_pad_oe     out 1  1 = pull SCL pad low (pad output value tied 0)
//  sda_pad_oe     out 1  1 = pull SDA pad low
//  m_scl_i        out 1  filtered SCL to master
//  m_sda_i        out 1  filtered SDA to master
//  m_scl_o, m_scl_t  in 1 each  master SCL value / tristate (t=1 release)
//  m_sda_o, m_sda_t  in 1 each  master SDA value / tristate
//  recover_req    in  1  one-cycle request to start bus recovery
//  recover_busy   out 1  recovery in progress
//  recover_done   out 1  one-cycle pulse when recovery ends
//  start_det      out 1  one-cycle START pulse
//  stop_det       out 1  one-cycle STOP pulse
//  bus_busy       out 1  START seen, no STOP/free timeout yet
//  scl_stuck      out 1  SCL low >= STUCK_CYCLES
// BEHAVIOUR
//  Reset: m_scl_i=m_sda_i=1; sync flops=1; pad_oe=0; all flags/pulses 0; recovery FSM in IDLE.
//  Sync: 2 flops per line. Filter: counter increments while sync2 != filtered, clears on agreement.
//   Filtered flips on the FILTER_CYCLES-th mismatch. Clean edge visible FILTER_CYCLES+2 clocks after
//   first sampling edge; 0 -> 2 clocks. Pulse < FILTER_CYCLES samples never propagates.
//  START: filtered SDA 1->0 with filtered SCL 1 in both previous and current cycle. STOP: same, SDA 0->1.
//   SCL and SDA flipping in the same cycle -> no START/STOP.
//  bus_busy: set on start_det; cleared on stop_det or after BUS_FREE_CYCLES consecutive SCL=SDA=1.
//   START wins over the free timer in the same cycle.
//  scl_stuck: counter runs while filtered SCL=0 and saturates at STUCK_CYCLES; flag = reached.
//   Counter and flag clear the cycle after SCL reads 1.
//  Normal drive: scl_pad_oe = ~m_scl_t & ~m_scl_o; sda_pad_oe likewise; combinational, 0 latency.
//  Recovery FSM (IDLE, CLK_LO, CLK_HI, STOP_LO, STOP_HI, DONE) overrides master drive while not IDLE:
//   - IDLE: recover_req -> CLK_LO, pulse count=0. recover_req ignored outside IDLE.
//   - CLK_LO: SCL low, SDA released, RECOVER_HALF cycles -> CLK_HI.
//   - CLK_HI: SCL released for RECOVER_HALF cycles, then count++.
//     If filtered SDA=1 or count=9 -> STOP_LO; else -> CLK_LO.
//     A clock-stretching slave (filtered SCL=0) holds the CLK_HI timer.
//   - STOP_LO: SCL low, SDA low, RECOVER_HALF cycles -> STOP_HI.
//   - STOP_HI: SCL released, SDA low, RECOVER_HALF cycles; then SDA released -> DONE.
//   - DONE: recover_done=1 for 1 cycle -> IDLE.
//   recover_busy = (state != IDLE && state != DONE).
//  Reset mid-recovery returns to IDLE immediately and releases both pads; no done pulse.
//  Counter widths via $clog2(param+1); all counters saturate, never wrap.
// STRUCTURE
//  Package i2c_cond_pkg: recovery state encoding, RECOVER_PULSES=9 constant.
//  Sub-module i2c_line_filter (2-FF sync + filter counter, param FILTER_CYCLES), instantiated for SCL and SDA.
//  Top: edge/START/STOP detect, busy/free timer, stuck counter, recovery FSM, pad drive mux.
// TESTING
//  1 Reset: after rst release, m_scl_i=m_sda_i=1, pad_oe=0, bus_busy=0.
//  2 FILTER_CYCLES=4: 3-cycle SDA low glitch -> m_sda_i stays 1.
//    Clean SDA fall -> m_sda_i=0 exactly 6 clocks after the sampling edge.
//  3 Pads drive START then STOP -> one start_det pulse, bus_busy=1, one stop_det pulse, bus_busy=0.
//    SCL and SDA falling in the same clock -> no start_det.
//  4 START with no STOP, lines high 256 clocks (BUS_FREE_CYCLES=256) -> bus_busy clears on that cycle.
//  5 SCL held low 65535 clocks -> scl_stuck=1; SCL released -> scl_stuck=0 next cycle.
//  6 Slave holds SDA low; recover_req -> 9 SCL pulses of 2*RECOVER_HALF, STOP, recover_done.
//    Repeat with SDA released after pulse 3 -> STOP after 3 pulses.

Source files
------------

// File: rtl/i2c_cond_pkg.sv
// Shared definitions for the I2C pad-side bus conditioner: recovery state
// encoding, the recovery pulse count and a counter-width helper.
package i2c_cond_pkg;

  typedef enum logic [2:0] {
    REC_IDLE    = 3'd0,
    REC_CLK_LO  = 3'd1,
    REC_CLK_HI  = 3'd2,
    REC_STOP_LO = 3'd3,
    REC_STOP_HI = 3'd4,
    REC_DONE    = 3'd5
  } rec_state_t;

  localparam int RECOVER_PULSES = 9;
  localparam int PULSE_W        = $clog2(RECOVER_PULSES + 1);

  // Width able to hold 0..max_val; a disabled (zero) limit still gets one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a glitch filter: the filtered level only
// follows the synchronised input after FILTER_CYCLES consecutive disagreements.
module i2c_line_filter
  import i2c_cond_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(FILTER_CYCLES);

  logic sync1;
  logic sync2;

  // Metastability guard; idles high like the released bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign level = sync2;
    end else begin : g_filter
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          filt;

      // Count disagreements; flip on the last one, any agreement restarts the count.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt  <= '0;
          filt <= 1'b1;
        end else if (sync2 == filt) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          filt <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign level = filt;
    end
  endgenerate

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Pad-side stage for i2c_master_wb: filters SCL/SDA, detects START/STOP,
// tracks bus busy, flags a stuck SCL and runs the 9-clock bus recovery.
//
// Recovery FSM
//   state   | meaning
//   IDLE    | master drives the pads
//   CLK_LO  | recovery clock low phase, SDA released
//   CLK_HI  | recovery clock high phase, timer held while a slave stretches
//   STOP_LO | SCL and SDA low ahead of the STOP
//   STOP_HI | SCL released, SDA still low
//   DONE    | SDA released (STOP), one-cycle done pulse
module i2c_bus_conditioner
  import i2c_cond_pkg::*;
#(
  parameter int FILTER_CYCLES   = 4,
  parameter int BUS_FREE_CYCLES = 256,
  parameter int STUCK_CYCLES    = 65535,
  parameter int RECOVER_HALF    = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic scl_pad_oe,
  output logic sda_pad_oe,
  output logic m_scl_i,
  output logic m_sda_i,
  input  logic m_scl_o,
  input  logic m_scl_t,
  input  logic m_sda_o,
  input  logic m_sda_t,
  input  logic recover_req,
  output logic recover_busy,
  output logic recover_done,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic scl_stuck
);

  localparam int FW = cnt_width(BUS_FREE_CYCLES);
  localparam int SW = cnt_width(STUCK_CYCLES);
  localparam int HW = cnt_width(RECOVER_HALF);

  localparam logic [FW-1:0]      FREE_MAX   = FW'(BUS_FREE_CYCLES);
  localparam logic [FW-1:0]      FREE_LAST  = (BUS_FREE_CYCLES == 0) ? '0 : FW'(BUS_FREE_CYCLES - 1);
  localparam logic [SW-1:0]      STUCK_MAX  = SW'(STUCK_CYCLES);
  localparam logic [HW-1:0]      HALF_LOAD  = HW'(RECOVER_HALF - 1);
  localparam logic [PULSE_W-1:0] PULSE_MAX  = PULSE_W'(RECOVER_PULSES);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RECOVER_PULSES - 1);

  logic scl_f, sda_f;
  logic scl_q, sda_q;
  logic free_hit;
  logic [FW-1:0]      free_cnt;
  logic [SW-1:0]      stuck_cnt;
  logic [HW-1:0]      half_tmr;
  logic [PULSE_W-1:0] pulse_cnt;
  logic half_tc, half_hold;
  logic rec_scl_low, rec_sda_low;
  rec_state_t state, next_state;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (scl_pad_i),
    .level (scl_f)
  );

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (sda_pad_i),
    .level (sda_f)
  );

  assign m_scl_i = scl_f;
  assign m_sda_i = sda_f;

  // Previous filtered levels for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // SCL must be high on both sides of the SDA edge, so simultaneous flips are ignored.
  assign start_det = scl_q & scl_f & sda_q & ~sda_f;
  assign stop_det  = scl_q & scl_f & ~sda_q & sda_f;

  // Idle-bus timer: consecutive cycles with both lines high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  free_cnt <= '0;
    else if (!(scl_f && sda_f)) free_cnt <= '0;
    else if (free_cnt != FREE_MAX) free_cnt <= free_cnt + 1'b1;
  end

  assign free_hit = (BUS_FREE_CYCLES != 0) && scl_f && sda_f && (free_cnt == FREE_LAST);

  // Busy flag; a START in the same cycle as the free timeout keeps the bus busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      bus_busy <= 1'b0;
    else if (start_det)            bus_busy <= 1'b1;
    else if (stop_det || free_hit) bus_busy <= 1'b0;
  end

  // SCL-low duration, saturating at the stuck limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        stuck_cnt <= '0;
    else if (scl_f)                  stuck_cnt <= '0;
    else if (stuck_cnt != STUCK_MAX) stuck_cnt <= stuck_cnt + 1'b1;
  end

  assign scl_stuck = (STUCK_CYCLES != 0) && (stuck_cnt == STUCK_MAX);

  assign half_tc   = (half_tmr == '0);
  assign half_hold = (state == REC_CLK_HI) && !scl_f;

  // Recovery state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= REC_IDLE;
    else      state <= next_state;
  end

  // Half-period down-counter reloaded on every state change, plus pulse count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_tmr  <= '0;
      pulse_cnt <= '0;
    end else begin
      if (next_state != state)        half_tmr <= HALF_LOAD;
      else if (!half_tc && !half_hold) half_tmr <= half_tmr - 1'b1;

      if (state == REC_IDLE) pulse_cnt <= '0;
      else if (state == REC_CLK_HI && next_state != REC_CLK_HI && pulse_cnt != PULSE_MAX)
        pulse_cnt <= pulse_cnt + 1'b1;
    end
  end

  // Recovery next-state; stop clocking once the slave lets SDA go or all pulses are out.
  always_comb begin
    next_state = state;
    case (state)
      REC_IDLE:    if (recover_req) next_state = REC_CLK_LO;
      REC_CLK_LO:  if (half_tc) next_state = REC_CLK_HI;
      REC_CLK_HI: begin
        if (half_tc && !half_hold) begin
          if (sda_f || pulse_cnt == PULSE_LAST) next_state = REC_STOP_LO;
          else                                  next_state = REC_CLK_LO;
        end
      end
      REC_STOP_LO: if (half_tc) next_state = REC_STOP_HI;
      REC_STOP_HI: if (half_tc) next_state = REC_DONE;
      REC_DONE:    next_state = REC_IDLE;
      default:     next_state = REC_IDLE;
    endcase
  end

  // Recovery pad pulls and status.
  always_comb begin
    rec_scl_low  = 1'b0;
    rec_sda_low  = 1'b0;
    recover_busy = 1'b0;
    recover_done = 1'b0;
    case (state)
      REC_CLK_LO: begin
        rec_scl_low  = 1'b1;
        recover_busy = 1'b1;
      end
      REC_CLK_HI:  recover_busy = 1'b1;
      REC_STOP_LO: begin
        rec_scl_low  = 1'b1;
        rec_sda_low  = 1'b1;
        recover_busy = 1'b1;
      end
      REC_STOP_HI: begin
        rec_sda_low  = 1'b1;
        recover_busy = 1'b1;
      end
      REC_DONE:    recover_done = 1'b1;
      default:     ;
    endcase
  end

  assign scl_pad_oe = (state == REC_IDLE) ? (~m_scl_t & ~m_scl_o) : rec_scl_low;
  assign sda_pad_oe = (state == REC_IDLE) ? (~m_sda_t & ~m_sda_o) : rec_sda_low;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: directed pad stimulus, with bus events
// (START, STOP, recovery done) checked in order by a separate monitor.
module tb_i2c_bus_conditioner;

  localparam int FILTER = 4;
  localparam int FREE   = 256;
  localparam int STUCK  = 65535;
  localparam int HALF   = 250;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tb_scl_low = 1'b0;
  logic tb_sda_low = 1'b0;
  logic scl_pad_i, sda_pad_i, scl_pad_oe, sda_pad_oe, m_scl_i, m_sda_i;
  logic m_scl_o = 1'b1, m_scl_t = 1'b1, m_sda_o = 1'b1, m_sda_t = 1'b1;
  logic recover_req = 1'b0;
  logic recover_busy, recover_done, start_det, stop_det, bus_busy, scl_stuck;

  // Open-drain wired-AND of DUT pulls and bench-side (slave) pulls.
  assign scl_pad_i = ~(scl_pad_oe | tb_scl_low);
  assign sda_pad_i = ~(sda_pad_oe | tb_sda_low);

  always #5 clk = ~clk;

  i2c_bus_conditioner #(
    .FILTER_CYCLES   (FILTER),
    .BUS_FREE_CYCLES (FREE),
    .STUCK_CYCLES    (STUCK),
    .RECOVER_HALF    (HALF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_pad_i    (scl_pad_i),
    .sda_pad_i    (sda_pad_i),
    .scl_pad_oe   (scl_pad_oe),
    .sda_pad_oe   (sda_pad_oe),
    .m_scl_i      (m_scl_i),
    .m_sda_i      (m_sda_i),
    .m_scl_o      (m_scl_o),
    .m_scl_t      (m_scl_t),
    .m_sda_o      (m_sda_o),
    .m_sda_t      (m_sda_t),
    .recover_req  (recover_req),
    .recover_busy (recover_busy),
    .recover_done (recover_done),
    .start_det    (start_det),
    .stop_det     (stop_det),
    .bus_busy     (bus_busy),
    .scl_stuck    (scl_stuck)
  );

  typedef enum int {EV_START = 0, EV_STOP = 1, EV_DONE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       pulses;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks   = 0;
  int  n_fail     = 0;
  int  rec_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic expect_ev(input ev_kind_t kind, input int pulses);
    ev_t e;
    e.kind   = kind;
    e.pulses = pulses;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input ev_kind_t kind, input int pulses);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_seq: got unexpected event %0d, expected none", kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_DONE && e.pulses != pulses)) begin
        n_fail++;
        $display("FAIL event_seq: got event %0d pulses %0d, expected event %0d pulses %0d",
                 kind, pulses, e.kind, e.pulses);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return m_scl_i;
      1:       return m_sda_i;
      2:       return recover_done;
      default: return (rec_pulses == 3);
    endcase
  endfunction

  // Advance until the selected signal shows val; running out of budget is a failure.
  task automatic wait_sig(input int sel, input logic val, input int budget, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick(1);
      found = (sig(sel) === val);
    end
    check(name, found, 1);
  endtask

  // Monitor: pops expected events as the DUT pulses them, and times recovery phases.
  initial begin : monitor
    int lo_len;
    int hi_len;
    lo_len = 0;
    hi_len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (start_det) pop_check(EV_START, 0);
      if (stop_det)  pop_check(EV_STOP, 0);
      if (recover_done) begin
        pop_check(EV_DONE, rec_pulses);
        rec_pulses = 0;
      end
      if (recover_busy && scl_pad_oe && !sda_pad_oe) lo_len++;
      else if (lo_len != 0) begin
        check("rec_clk_lo_len", lo_len, HALF);
        rec_pulses++;
        lo_len = 0;
      end
      if (recover_busy && !scl_pad_oe && !sda_pad_oe) hi_len++;
      else if (hi_len != 0) begin
        // High phase also includes the filter delay before SCL reads back high.
        check_range("rec_clk_hi_len", hi_len, HALF, HALF + 8);
        hi_len = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Slave holds SDA low: SCL low, SDA low, then release SCL without any bus event.
  task automatic hold_sda_stuck();
    tb_scl_low = 1'b1; tick(10);
    tb_sda_low = 1'b1; tick(10);
    tb_scl_low = 1'b0; tick(20);
  endtask

  task automatic free_sda_quietly();
    tb_scl_low = 1'b1; tick(10);
    tb_sda_low = 1'b0; tick(10);
    tb_scl_low = 1'b0; tick(20);
  endtask

  initial begin : stim
    logic saw_low;

    // Reset
    rst = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(2);
    check("rst_m_scl_i",      m_scl_i,      1);
    check("rst_m_sda_i",      m_sda_i,      1);
    check("rst_scl_pad_oe",   scl_pad_oe,   0);
    check("rst_sda_pad_oe",   sda_pad_oe,   0);
    check("rst_bus_busy",     bus_busy,     0);
    check("rst_scl_stuck",    scl_stuck,    0);
    check("rst_recover_busy", recover_busy, 0);

    // 3-sample SDA glitch must be swallowed
    tb_sda_low = 1'b1;
    tick(3);
    tb_sda_low = 1'b0;
    saw_low = 1'b0;
    repeat (12) begin
      tick(1);
      if (!m_sda_i) saw_low = 1'b1;
    end
    check("glitch_sda_low_seen", saw_low, 0);

    // Clean SDA fall with SCL high: visible on the 6th edge, and it is a START
    expect_ev(EV_START, 0);
    tb_sda_low = 1'b1;
    tick(5);
    check("sda_fall_edge5", m_sda_i, 1);
    tick(1);
    check("sda_fall_edge6", m_sda_i, 0);
    tick(2);
    check("busy_after_start", bus_busy, 1);

    // Leave the bus idle without a STOP; busy clears after 256 idle cycles
    tb_scl_low = 1'b1; tick(10);
    tb_sda_low = 1'b0; tick(10);
    tb_scl_low = 1'b0;
    wait_sig(0, 1'b1, 20, "free_scl_rise");
    tick(FREE - 1);
    check("busy_free_minus1", bus_busy, 1);
    tick(1);
    check("busy_free_expired", bus_busy, 0);

    // START then STOP
    expect_ev(EV_START, 0);
    tb_sda_low = 1'b1; tick(10);
    check("busy_start2", bus_busy, 1);
    tb_scl_low = 1'b1; tick(10);
    tb_scl_low = 1'b0; tick(10);
    expect_ev(EV_STOP, 0);
    tb_sda_low = 1'b0; tick(10);
    check("busy_after_stop", bus_busy, 0);

    // SCL and SDA falling together is not a START
    tb_scl_low = 1'b1;
    tb_sda_low = 1'b1;
    tick(10);
    check("simul_fall_busy", bus_busy, 0);
    tb_sda_low = 1'b0; tick(10);
    tb_scl_low = 1'b0; tick(10);

    // Master drive passes straight through to the pad enables (within one clock period)
    m_scl_t = 1'b0; m_scl_o = 1'b0; #1;
    check("drive_scl_low", scl_pad_oe, 1);
    m_sda_t = 1'b0; m_sda_o = 1'b0; #1;
    check("drive_sda_low", sda_pad_oe, 1);
    m_sda_o = 1'b1; #1;
    check("drive_sda_high", sda_pad_oe, 0);
    m_scl_o = 1'b1; #1;
    check("drive_scl_high", scl_pad_oe, 0);
    m_sda_t = 1'b1; m_scl_t = 1'b1; m_sda_o = 1'b0; m_scl_o = 1'b0; #1;
    check("drive_scl_released", scl_pad_oe, 0);
    check("drive_sda_released", sda_pad_oe, 0);
    m_sda_o = 1'b1; m_scl_o = 1'b1;
    tick(1);

    // SCL held low until the stuck limit
    tb_scl_low = 1'b1;
    wait_sig(0, 1'b0, 20, "stuck_scl_fall");
    tick(STUCK - 1);
    check("stuck_before_limit", scl_stuck, 0);
    tick(1);
    check("stuck_at_limit", scl_stuck, 1);
    tb_scl_low = 1'b0;
    wait_sig(0, 1'b1, 20, "stuck_scl_rise");
    check("stuck_on_release", scl_stuck, 1);
    tick(1);
    check("stuck_cleared", scl_stuck, 0);
    tick(5);

    // Recovery with SDA stuck throughout: all 9 pulses
    hold_sda_stuck();
    expect_ev(EV_DONE, 9);
    recover_req = 1'b1;
    tick(1);
    recover_req = 1'b0;
    check("rec9_busy", recover_busy, 1);
    check("rec9_scl_oe", scl_pad_oe, 1);
    wait_sig(2, 1'b1, 12000, "rec9_done");
    check("rec9_busy_at_done", recover_busy, 0);
    check("rec9_scl_released", scl_pad_oe, 0);
    check("rec9_sda_released", sda_pad_oe, 0);
    tick(20);
    free_sda_quietly();

    // Recovery where the slave lets go during pulse 3
    hold_sda_stuck();
    expect_ev(EV_STOP, 0);
    expect_ev(EV_DONE, 3);
    expect_ev(EV_STOP, 0);
    recover_req = 1'b1;
    tick(1);
    recover_req = 1'b0;
    wait_sig(3, 1'b1, 3000, "rec3_third_high");
    wait_sig(0, 1'b1, 20, "rec3_scl_high");
    tick(20);
    tb_sda_low = 1'b0;
    wait_sig(2, 1'b1, 3000, "rec3_done");
    tick(20);
    check("rec3_busy_idle", recover_busy, 0);

    check("events_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
